str_num_parser: RTL and testbench
=================================

# str_num_parser

Streaming ASCII-to-integer parser: accepts one character per cycle over a valid/ready byte stream and returns the numeric value of the string. It is the read side of the string-formatting path: text produced by `$sformat`-style formatting is converted back to a binary value with `atoi`/`atohex`/`atooct`/`atobin` semantics. It sits between a character source, such as a UART RX or string FIFO, and a register-write consumer.

## Interface
- `WIDTH`, 32: result width in bits.
- `CNT_W`, 8: width of the digit counter.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  character present.
- `in_ready`  out  1  parser can accept a character.
- `in_data`  in  8  ASCII character.
- `in_last`  in  1  marks the final character of the string.
- `radix`  in  2  0=dec, 1=hex, 2=oct, 3=bin; sampled with the first character of each string.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_value`  out  WIDTH  parsed value.
- `out_ndigits`  out  CNT_W  digits consumed; saturates at 2^CNT_W-1.
- `out_overflow`  out  1  value exceeded WIDTH bits and wrapped.
- `out_err`  out  1  parse stopped on a non-digit character other than NUL.

## Operation
- States:
  - IDLE: waiting for the first character.
  - ACCUM: accumulating digits.
  - SKIP: draining the remaining characters after a stop.
  - DONE: result held for the consumer.
- Transfer: a character is transferred when `in_valid && in_ready`.
- `in_ready`: 1 in IDLE, ACCUM and SKIP; 0 in DONE.
- IDLE, on transfer:
  - Latch `radix`.
  - Clear the accumulator, counter and flags.
  - Process the character as in ACCUM.
- Digit set per radix:
  - dec: 0-9.
  - hex: 0-9, a-f, A-F.
  - oct: 0-7.
  - bin: 0-1.
- Digit: `acc = acc*radix + digit`, computed at WIDTH+4 bits.
  - Nonzero upper bits set the sticky `out_overflow`.
  - `acc` keeps the low WIDTH bits.
  - `out_ndigits` increments.
- `_`: ignored everywhere, with no state change.
- Any other character stops the parse:
  - Go to SKIP; the accumulator is frozen.
  - `out_err` is set unless the character is 8'h00.
- SKIP: accepts and discards characters until `in_last`.
- `in_last` on any transfer: the current character is processed first, then the FSM goes to DONE.
- DONE:
  - `out_valid`=1 and all outputs are stable.
  - On `out_valid && out_ready`, go to IDLE.
- Empty result: a string with no digits yields 0 with `out_ndigits`=0.
- Reset values:
  - State IDLE.
  - `out_valid`=0, `out_value`=0, `out_ndigits`=0, `out_overflow`=0, `out_err`=0.
  - `in_ready`=1 once `rst_n` is high.
- Reset mid-string: the partial string is discarded. The next character starts a new string.

## Timing
- Throughput: one character per cycle, with no bubbles inside a string.
- Result latency: `out_valid` rises one cycle after the edge that accepts the `in_last` character.
- Outputs are registered and hold while `out_valid && !out_ready`.
- Turnaround: after the output handshake edge, `in_ready` is 1 in the next cycle. A string of N characters therefore occupies at least N+1 cycles.
- `radix` is ignored except in the cycle of the first transfer of a string.

## Configuration
- `STR_PARSE_SIGN_EN` defined:
  - In decimal mode, `-` or `+` is accepted as the first non-`_` character.
  - A `-` causes two's-complement negation of the WIDTH-bit result on entry to DONE.
  - Overflow is judged on the magnitude.
- Undefined:
  - `+` and `-` are ordinary non-digits: they stop the parse and set `out_err`.
  - No sign logic is present.

## Structure
- Package `str_parse_pkg` holds:
  - `radix_e` enum.
  - `state_e` enum (IDLE, ACCUM, SKIP, DONE).
  - Radix-value constants (10/16/8/2).
- One sub-module: `str_digit_decode`.
  - Combinational.
  - Inputs: `in_data` and the latched radix.
  - Outputs: `is_digit`, `digit[3:0]`, `is_underscore`, `is_nul`, `is_sign`.
- The top level holds the FSM, the accumulator and the output registers.

## Test plan
- Decimal with underscore: dec "1_234" with `in_last` on '4' → `out_value`=32'd1234, `out_ndigits`=4, `out_err`=0, `out_valid` one cycle after the last transfer.
- Hex, mixed case: hex "dEaDbeef" → 32'hDEADBEEF; hex "1_0000_0000" → `out_overflow`=1, `out_value`=0.
- Early stop: oct "17x9", then bin "102" → 32'o17 with `out_err`=1 and 4 characters accepted; then 32'b10 with `out_err`=1. A NUL stop gives `out_err`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles → outputs stable, `in_ready`=0; release → the next string is accepted the cycle after the handshake.
- Reset mid-string: "12" then assert `rst_n`=0 → all outputs return to their reset values; a following string "7" → 7.
- With `STR_PARSE_SIGN_EN`: dec "-5" → 32'hFFFF_FFFB. Without it, dec "-5" → 0 with `out_err`=1.

Source files
------------

// File: rtl/str_parse_pkg.sv
// Shared types and radix constants for the streaming ASCII-to-integer parser.
package str_parse_pkg;

   typedef enum logic [1:0] {
      RADIX_DEC = 2'd0,
      RADIX_HEX = 2'd1,
      RADIX_OCT = 2'd2,
      RADIX_BIN = 2'd3
   } radix_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SKIP  = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [4:0] RADIX_VAL_DEC = 5'd10;
   localparam logic [4:0] RADIX_VAL_HEX = 5'd16;
   localparam logic [4:0] RADIX_VAL_OCT = 5'd8;
   localparam logic [4:0] RADIX_VAL_BIN = 5'd2;

   function automatic logic [4:0] radix_value(input radix_e r);
      case (r)
         RADIX_HEX: radix_value = RADIX_VAL_HEX;
         RADIX_OCT: radix_value = RADIX_VAL_OCT;
         RADIX_BIN: radix_value = RADIX_VAL_BIN;
         default:   radix_value = RADIX_VAL_DEC;
      endcase
   endfunction

endpackage

// File: rtl/str_digit_decode.sv
// Combinational character classifier: digit membership and value for the
// selected radix, plus the underscore, NUL and sign character classes.
module str_digit_decode
   import str_parse_pkg::*;
(
   input  logic [7:0] in_data,
   input  logic [1:0] radix,
   output logic       is_digit,
   output logic [3:0] digit,
   output logic       is_underscore,
   output logic       is_nul,
   output logic       is_sign
);

   logic w_dec;
   logic w_lower;
   logic w_upper;
   logic w_oct;
   logic w_bin;

   assign w_dec   = (in_data >= 8'h30) && (in_data <= 8'h39);
   assign w_lower = (in_data >= 8'h61) && (in_data <= 8'h66);
   assign w_upper = (in_data >= 8'h41) && (in_data <= 8'h46);
   assign w_oct   = (in_data >= 8'h30) && (in_data <= 8'h37);
   assign w_bin   = (in_data == 8'h30) || (in_data == 8'h31);

   always_comb begin
      is_digit = 1'b0;
      case (radix_e'(radix))
         RADIX_DEC: is_digit = w_dec;
         RADIX_HEX: is_digit = w_dec || w_lower || w_upper;
         RADIX_OCT: is_digit = w_oct;
         RADIX_BIN: is_digit = w_bin;
         default:   is_digit = 1'b0;
      endcase
   end

   // 'a'/'A' have low nibble 1, so letters map to nibble+9
   assign digit         = w_dec ? in_data[3:0] : (in_data[3:0] + 4'd9);
   assign is_underscore = (in_data == 8'h5F);
   assign is_nul        = (in_data == 8'h00);
   assign is_sign       = (in_data == 8'h2B) || (in_data == 8'h2D);

endmodule

// File: rtl/str_num_parser.sv
// Streaming ASCII-to-integer parser (atoi/atohex/atooct/atobin semantics).
// Define STR_PARSE_SIGN_EN to accept a leading +/- in decimal mode.
module str_num_parser
   import str_parse_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   input  logic [1:0]       radix,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_value,
   output logic [CNT_W-1:0] out_ndigits,
   output logic             out_overflow,
   output logic             out_err
);

   localparam int AW = WIDTH + 4;

   state_e           r_state;
   radix_e           r_radix;
   logic [WIDTH-1:0] r_value;
   logic [CNT_W-1:0] r_ndigits;
   logic             r_overflow;
   logic             r_err;
`ifdef STR_PARSE_SIGN_EN
   logic             r_neg;
   logic             r_started;
   logic             w_neg_next;
   logic             w_started_next;
`endif

   logic             w_idle;
   logic             w_xfer;
   radix_e           w_radix;
   logic             w_is_digit;
   logic [3:0]       w_digit;
   logic             w_is_underscore;
   logic             w_is_nul;
   logic             w_is_sign;
   logic [WIDTH-1:0] w_acc_base;
   logic [CNT_W-1:0] w_cnt_base;
   logic [AW-1:0]    w_wide;
   logic [WIDTH-1:0] w_acc_next;
   logic [WIDTH-1:0] w_value_next;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_ovf_next;
   logic             w_err_next;
   state_e           w_state_next;

   assign w_idle   = (r_state == IDLE);
   assign in_ready = (r_state != DONE);
   assign w_xfer   = in_valid && in_ready;
   assign w_radix  = w_idle ? radix_e'(radix) : r_radix;

   str_digit_decode u_decode (
      .in_data       (in_data),
      .radix         (w_radix),
      .is_digit      (w_is_digit),
      .digit         (w_digit),
      .is_underscore (w_is_underscore),
      .is_nul        (w_is_nul),
      .is_sign       (w_is_sign)
   );

   // The first character of a string starts from a cleared accumulator
   assign w_acc_base = w_idle ? '0 : r_value;
   assign w_cnt_base = w_idle ? '0 : r_ndigits;
   assign w_wide     = AW'(w_acc_base) * AW'(radix_value(w_radix)) + AW'(w_digit);

   always_comb begin
      w_acc_next   = w_acc_base;
      w_cnt_next   = w_cnt_base;
      w_ovf_next   = !w_idle && r_overflow;
      w_err_next   = !w_idle && r_err;
      w_state_next = (r_state == SKIP) ? SKIP : ACCUM;
`ifdef STR_PARSE_SIGN_EN
      w_neg_next     = !w_idle && r_neg;
      w_started_next = !w_idle && r_started;
`endif
      if ((r_state != SKIP) && !w_is_underscore) begin
         if (w_is_digit) begin
            w_acc_next = w_wide[WIDTH-1:0];
            w_ovf_next = w_ovf_next || (|w_wide[AW-1:WIDTH]);
            if (w_cnt_base != {CNT_W{1'b1}})
               w_cnt_next = w_cnt_base + 1'b1;
`ifdef STR_PARSE_SIGN_EN
            w_started_next = 1'b1;
         end else if ((w_radix == RADIX_DEC) && w_is_sign && !w_started_next) begin
            w_neg_next     = (in_data == 8'h2D);
            w_started_next = 1'b1;
         end else begin
            w_state_next = SKIP;
            w_err_next   = w_err_next || !w_is_nul;
         end
`else
         end else begin
            // +/- are plain non-digits without sign support
            w_state_next = SKIP;
            w_err_next   = w_err_next || w_is_sign || !w_is_nul;
         end
`endif
      end
      if (in_last)
         w_state_next = DONE;
      w_value_next = w_acc_next;
`ifdef STR_PARSE_SIGN_EN
      if (in_last && w_neg_next)
         w_value_next = -w_acc_next;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_radix    <= RADIX_DEC;
         r_value    <= '0;
         r_ndigits  <= '0;
         r_overflow <= 1'b0;
         r_err      <= 1'b0;
`ifdef STR_PARSE_SIGN_EN
         r_neg      <= 1'b0;
         r_started  <= 1'b0;
`endif
      end else begin
         case (r_state)
            DONE: begin
               if (out_ready)
                  r_state <= IDLE;
            end
            default: begin
               if (w_xfer) begin
                  r_state    <= w_state_next;
                  r_value    <= w_value_next;
                  r_ndigits  <= w_cnt_next;
                  r_overflow <= w_ovf_next;
                  r_err      <= w_err_next;
`ifdef STR_PARSE_SIGN_EN
                  r_neg      <= w_neg_next;
                  r_started  <= w_started_next;
`endif
                  if (w_idle)
                     r_radix <= w_radix;
               end
            end
         endcase
      end
   end

   assign out_valid    = (r_state == DONE);
   assign out_value    = r_value;
   assign out_ndigits  = r_ndigits;
   assign out_overflow = r_overflow;
   assign out_err      = r_err;

endmodule

// File: tb/tb_str_num_parser.sv
// Directed-vector bench for str_num_parser; '~' in a test string stands for NUL.
module tb_str_num_parser;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        in_last;
   logic [1:0]  radix;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_value;
   logic [7:0]  out_ndigits;
   logic        out_overflow;
   logic        out_err;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   str_num_parser #(.WIDTH(32), .CNT_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .radix        (radix),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_value    (out_value),
      .out_ndigits  (out_ndigits),
      .out_overflow (out_overflow),
      .out_err      (out_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Streams one string back-to-back; radix is scrambled after the first char.
   task automatic send(input string tag, input string s, input logic [1:0] rdx, input bit last_flag);
      logic [7:0] ch;
      for (int i = 0; i < s.len(); i++) begin
         ch       = s[i];
         in_valid = 1'b1;
         in_data  = (ch == 8'h7E) ? 8'h00 : ch;
         in_last  = last_flag && (i == s.len() - 1);
         radix    = (i == 0) ? rdx : ~rdx;
         check($sformatf("%s rdy[%0d]", tag, i), in_ready, 1);
         check($sformatf("%s nvalid[%0d]", tag, i), out_valid, 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'h00;
      $display("sent %s \"%s\" radix=%0d", tag, s, rdx);
   endtask

   task automatic expect_result(input string tag, input logic [31:0] v, input int nd,
                                input bit ovf, input bit err);
      check({tag, " valid"}, out_valid, 1);
      check({tag, " value"}, out_value, v);
      check({tag, " ndigits"}, out_ndigits, nd);
      check({tag, " ovf"}, out_overflow, ovf);
      check({tag, " err"}, out_err, err);
      $display("result %s value=%0h ndigits=%0d ovf=%0b err=%0b",
               tag, out_value, out_ndigits, out_overflow, out_err);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " ready_after"}, in_ready, 1);
      check({tag, " valid_after"}, out_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_last   = 1'b0;
      radix     = 2'd0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst valid", out_valid, 0);
      check("rst value", out_value, 0);
      check("rst ndigits", out_ndigits, 0);
      check("rst ovf", out_overflow, 0);
      check("rst err", out_err, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst ready", in_ready, 1);

      send("dec1234", "1_234", 2'd0, 1'b1);
      expect_result("dec1234", 32'd1234, 4, 1'b0, 1'b0);

      send("hexdead", "dEaDbeef", 2'd1, 1'b1);
      expect_result("hexdead", 32'hDEADBEEF, 8, 1'b0, 1'b0);

      send("hexovf", "1_0000_0000", 2'd1, 1'b1);
      expect_result("hexovf", 32'h0, 9, 1'b1, 1'b0);

      send("oct17x9", "17x9", 2'd2, 1'b1);
      expect_result("oct17x9", 32'o17, 2, 1'b0, 1'b1);

      send("bin102", "102", 2'd3, 1'b1);
      expect_result("bin102", 32'b10, 2, 1'b0, 1'b1);

      send("decnul", "5~3", 2'd0, 1'b1);
      expect_result("decnul", 32'd5, 1, 1'b0, 1'b0);

      send("decmax", "4294967295", 2'd0, 1'b1);
      expect_result("decmax", 32'hFFFFFFFF, 10, 1'b0, 1'b0);

      send("decwrap", "4294967296", 2'd0, 1'b1);
      expect_result("decwrap", 32'h0, 10, 1'b1, 1'b0);

      send("empty", "_", 2'd0, 1'b1);
      expect_result("empty", 32'h0, 0, 1'b0, 1'b0);

      // Backpressure: result must hold and input must stall
      send("bp42", "42", 2'd0, 1'b1);
      in_valid = 1'b1;
      in_data  = 8'h39;
      in_last  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         check($sformatf("bp valid[%0d]", c), out_valid, 1);
         check($sformatf("bp ready[%0d]", c), in_ready, 0);
         check($sformatf("bp value[%0d]", c), out_value, 32'd42);
         check($sformatf("bp nd[%0d]", c), out_ndigits, 2);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      expect_result("bp42", 32'd42, 2, 1'b0, 1'b0);
      send("bp8", "8", 2'd0, 1'b1);
      expect_result("bp8", 32'd8, 1, 1'b0, 1'b0);

      // Reset in the middle of a string
      send("partial", "12", 2'd0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst valid", out_valid, 0);
      check("midrst value", out_value, 0);
      check("midrst ndigits", out_ndigits, 0);
      check("midrst ovf", out_overflow, 0);
      check("midrst err", out_err, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("midrst ready", in_ready, 1);
      send("after", "7", 2'd0, 1'b1);
      expect_result("after", 32'd7, 1, 1'b0, 1'b0);

      send("neg5", "-5", 2'd0, 1'b1);
`ifdef STR_PARSE_SIGN_EN
      expect_result("neg5", 32'hFFFF_FFFB, 1, 1'b0, 1'b0);
`else
      expect_result("neg5", 32'h0, 0, 1'b0, 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
